// File: rtl/mips_pkg.sv
// Opcode/funct constants, loader op-select encoding and FSM state type
// shared by the instruction encoder and the loader control.
package mips_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_ADDI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_J    = 4'd9
  } op_sel_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } ld_state_e;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Request and instruction-memory write channels of the loader.
// slave = loader side, master = requester / memory side.
interface instr_loader_if #(
  parameter int AW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational MIPS encoder: op select + fields -> 32-bit word and legal flag.
module instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      OP_ADD:  word = r_type(rs, rt, rd, FN_ADD);
      OP_SUB:  word = r_type(rs, rt, rd, FN_SUB);
      OP_AND:  word = r_type(rs, rt, rd, FN_AND);
      OP_OR:   word = r_type(rs, rt, rd, FN_OR);
      OP_SLT:  word = r_type(rs, rt, rd, FN_SLT);
      OP_ADDI: word = i_type(OPC_ADDI, rs, rt, imm);
      OP_LW:   word = i_type(OPC_LW, rs, rt, imm);
      OP_SW:   word = i_type(OPC_SW, rs, rt, imm);
      OP_BEQ:  word = i_type(OPC_BEQ, rs, rt, imm);
      OP_J:    word = {OPC_J, target};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Accepts instruction requests, encodes them and writes them sequentially
// into instruction memory, tracking fill level and illegal requests.
module instr_loader
  import mips_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  instr_loader_if.slave  bus,
  output logic [AW:0]    count,
  output logic           full,
  output logic           illegal
);

  localparam logic [AW:0] LAST_CNT = {1'b0, {AW{1'b1}}};

  ld_state_e     state_q, state_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          illegal_q, illegal_d;

  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          in_ready;

  instr_pack u_pack (
    .op     (bus.in_op),
    .rs     (bus.in_rs),
    .rt     (bus.in_rt),
    .rd     (bus.in_rd),
    .imm    (bus.in_imm),
    .target (bus.in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  // Ready is held low throughout reset and whenever a clear is requested.
  assign in_ready = rst_n && (state_q == ST_IDLE) && !clear;

  always_comb begin
    state_d   = state_q;
    mem_we_d  = mem_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    full_d    = full_q;
    illegal_d = illegal_q;
    if (clear) begin
      state_d   = ST_IDLE;
      mem_we_d  = 1'b0;
      addr_d    = '0;
      count_d   = '0;
      full_d    = 1'b0;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (enc_legal) begin
              wdata_d  = enc_word;
              mem_we_d = 1'b1;
              state_d  = ST_WRITE;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (bus.mem_ready) begin
            mem_we_d = 1'b0;
            count_d  = count_q + 1'b1;
            // Last location: address parks at the top instead of wrapping.
            if (count_q == LAST_CNT) begin
              full_d  = 1'b1;
              state_d = ST_FULL;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_FULL: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_we_q  <= mem_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      count_q   <= count_d;
      full_q    <= full_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign count         = count_q;
  assign full          = full_q;
  assign illegal       = illegal_q;

endmodule
